serializador_mante: RTL and testbench
=====================================

SERIALIZADOR_MANTE -- requirements
Module: serializador_mante

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..255.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 The block SHALL have port data_input  input  8  parallel byte from the 8-bit holding register.
REQ-005 The block SHALL have port load  input  1  request to transmit data_input.
REQ-006 The block SHALL have port ready  output  1  high when a load will be accepted.
REQ-007 The block SHALL have port tx_out  output  1  serial line; idle level 1.
REQ-008 The block SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse on frame completion.

Function
REQ-010 The block SHALL use one clock and a synchronous, active-high reset; there is no asynchronous logic.
REQ-011 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-012 In IDLE, ready SHALL be 1, busy 0 and tx_out 1.
REQ-013 A load SHALL be accepted only on a rising edge where load=1 and ready=1; data_input is captured into an internal shift register on that edge.
REQ-014 On acceptance the FSM SHALL go IDLE->START; on that same edge tx_out SHALL become 0 and ready SHALL become 0.
REQ-015 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter that runs 0..CLKS_PER_BIT-1 and wraps to 0.
REQ-016 START SHALL drive tx_out=0 for one bit period, then go to DATA.
REQ-017 DATA SHALL send 8 bits LSB first (bit0 first), using a 3-bit index 0..7; the FSM goes to STOP after bit 7's period.
REQ-018 STOP SHALL drive tx_out=1 for one bit period, then go to IDLE.
REQ-019 A full frame SHALL span exactly 10*CLKS_PER_BIT cycles, from the acceptance edge to the edge that returns the FSM to IDLE.
REQ-020 done SHALL be 1 for exactly the one cycle after the STOP->IDLE edge; otherwise done is 0.
REQ-021 busy SHALL equal NOT ready in every cycle.
REQ-022 load while busy=1 SHALL be ignored: no capture and no queueing, and the frame in flight is unaffected.
REQ-023 Changes on data_input after acceptance SHALL NOT affect the frame in flight.
REQ-024 A load asserted in the cycle done=1 SHALL be accepted, because ready is already 1; frames can therefore run back-to-back with zero idle bit periods.
REQ-025 All outputs SHALL be registered and glitch-free; tx_out SHALL come from a flop.

Reset
REQ-026 On a rising edge with reset=1, the state SHALL become IDLE, tx_out=1, ready=1, busy=0, done=0, and the bit counter, bit index and shift register SHALL clear to 0.
REQ-027 reset SHALL take priority over load on the same edge; that load is dropped.
REQ-028 reset mid-frame SHALL abort the frame immediately, with no done pulse, and tx_out SHALL return to 1 on that edge.

Verification (CLKS_PER_BIT=4)
REQ-029 The bench SHALL check basic frame: load 0xA5 for one cycle from IDLE -> tx_out over 40 cycles = 0, 1,0,1,0,0,1,0,1, 1 (each 4 cycles), then done=1 for 1 cycle, then ready=1.
REQ-030 The bench SHALL check busy-ignore: load 0x3C, then at cycle 10 assert load with data_input=0xFF -> transmitted bits are still 0x3C, and exactly one done pulse occurs.
REQ-031 The bench SHALL check back-to-back: load 0x01, then load 0x80 in the done cycle -> second start bit begins on that edge, and the two frames total 80 cycles with no idle gap.
REQ-032 The bench SHALL check reset mid-frame: reset during DATA bit 3 -> next cycle tx_out=1, ready=1, done never pulses, and a later load 0x55 sends a clean frame.
REQ-033 The bench SHALL check reset vs load: reset=1 and load=1 on the same edge with 0x0F -> block stays IDLE and tx_out stays 1 for 20 cycles.
REQ-034 The bench SHALL check boundary data: frames 0x00 and 0xFF -> 8 data bit periods all 0 or all 1, with framing bits correct and length exactly 40 cycles.

Source files
------------

// File: rtl/serializador_mante_if.sv
// Load/serial handshake bundle for serializador_mante.
// The master side supplies the byte and load request; the slave side reports line and status.
interface serializador_mante_if;
  logic [7:0] data_input;
  logic       load;
  logic       ready;
  logic       tx_out;
  logic       busy;
  logic       done;

  modport master (
    output data_input, load,
    input  ready, tx_out, busy, done
  );

  modport slave (
    input  data_input, load,
    output ready, tx_out, busy, done
  );
endinterface

// File: rtl/serializador_mante.sv
// 8N1 serializer: start bit, eight data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
// All outputs come straight from flops; ready returns with done, so frames can run back-to-back.
module serializador_mante #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  serializador_mante_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_end;

  assign bit_end = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.load && ready_q) begin
          state_d = START;
          shift_d = bus.data_input;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // The next bit is loaded into tx one edge ahead so the line stays flop-driven.
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_serializador_mante.sv
// Bench for serializador_mante: frame vector table, hand-written corner sequences,
// then random load/reset traffic compared against a frame-position reference model.
module tb_serializador_mante;

  localparam int N = 4;
  localparam int FRAME = 10 * N;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  serializador_mante_if bus();

  serializador_mante #(.CLKS_PER_BIT(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_frame;     // bit i is the i-th bit on the line
    int         intrude_at;    // frame cycle for an extra load, -1 for none
    logic [7:0] intrude_data;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue a one-cycle load from IDLE; returns in frame cycle 0.
  task automatic start_frame(input logic [7:0] data);
    bus.load       = 1'b1;
    bus.data_input = data;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Walk one frame from cycle 0 through the done cycle, checking every cycle.
  task automatic frame_body(input logic [9:0] exp, input int intrude_at,
                            input logic [7:0] intrude_data,
                            input logic chain, input logic [7:0] chain_data);
    int dones;
    dones = 0;
    for (int c = 0; c < FRAME; c++) begin
      chk("frame_tx", 32'(bus.tx_out), 32'(exp[c / N]));
      chk("frame_busy_ready", {30'd0, bus.busy, bus.ready}, 32'b10);
      if (bus.done) dones++;
      bus.load       = (c == intrude_at);
      bus.data_input = (c == intrude_at) ? intrude_data : 8'($urandom);
      @(negedge clk);
    end
    bus.load = 1'b0;
    chk("frame_no_early_done", 32'(dones), 32'd0);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("ready_after_frame", 32'(bus.ready), 32'd1);
    chk("tx_idle_after_frame", 32'(bus.tx_out), 32'd1);
    if (chain) begin
      bus.load       = 1'b1;
      bus.data_input = chain_data;
      @(negedge clk);
      bus.load = 1'b0;
    end else begin
      @(negedge clk);
      chk("done_single_cycle", 32'(bus.done), 32'd0);
    end
  endtask

  // Reference model: only tracks whether a frame is active and how far into it we are.
  bit         m_active;
  bit         m_done;
  int         m_k;
  logic [9:0] m_frame;

  initial begin
    vecs[0] = '{8'hA5, 10'h34A, -1, 8'h00};
    vecs[1] = '{8'h00, 10'h200, -1, 8'h00};
    vecs[2] = '{8'hFF, 10'h3FE, -1, 8'h00};
    vecs[3] = '{8'h3C, 10'h278, 10, 8'hFF};

    reset          = 1'b1;
    bus.load       = 1'b0;
    bus.data_input = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_tx", 32'(bus.tx_out), 32'd1);
    chk("reset_ready", 32'(bus.ready), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      start_frame(vecs[i].data);
      frame_body(vecs[i].exp_frame, vecs[i].intrude_at, vecs[i].intrude_data, 1'b0, 8'h00);
    end

    // Back-to-back: second load lands in the done cycle of the first frame.
    start_frame(8'h01);
    frame_body(10'h202, -1, 8'h00, 1'b1, 8'h80);
    frame_body(10'h300, -1, 8'h00, 1'b0, 8'h00);

    // Reset during DATA bit 3 (frame cycles 16..19).
    start_frame(8'hC3);
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_tx", 32'(bus.tx_out), 32'd1);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    for (int c = 0; c < 50; c++) begin
      chk("abort_no_done", 32'(bus.done), 32'd0);
      chk("abort_tx_idle", 32'(bus.tx_out), 32'd1);
      @(negedge clk);
    end
    start_frame(8'h55);
    frame_body(10'h2AA, -1, 8'h00, 1'b0, 8'h00);

    // Reset and load on the same edge: load is dropped.
    reset          = 1'b1;
    bus.load       = 1'b1;
    bus.data_input = 8'h0F;
    @(negedge clk);
    reset    = 1'b0;
    bus.load = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk("rst_load_tx", 32'(bus.tx_out), 32'd1);
      chk("rst_load_ready", 32'(bus.ready), 32'd1);
      @(negedge clk);
    end

    // Random traffic against the reference model.
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    m_active = 0;
    m_done   = 0;
    m_k      = 0;
    m_frame  = '1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       r_load, r_rst;
      logic [7:0] r_data;
      chk("rand_tx", 32'(bus.tx_out), m_active ? 32'(m_frame[m_k / N]) : 32'd1);
      chk("rand_ready", 32'(bus.ready), 32'(!m_active));
      chk("rand_busy", 32'(bus.busy), 32'(m_active));
      chk("rand_done", 32'(bus.done), 32'(m_done));
      r_load = ($urandom_range(0, 2) == 0);
      r_rst  = ($urandom_range(0, 249) == 0);
      r_data = 8'($urandom);
      bus.load       = r_load;
      bus.data_input = r_data;
      reset          = r_rst;
      if (r_rst) begin
        m_active = 0;
        m_done   = 0;
      end else if (m_active) begin
        if (m_k == FRAME - 1) begin
          m_active = 0;
          m_done   = 1;
        end else begin
          m_k++;
          m_done = 0;
        end
      end else begin
        m_done = 0;
        if (r_load) begin
          m_active = 1;
          m_k      = 0;
          m_frame  = {1'b1, r_data, 1'b0};
        end
      end
      @(negedge clk);
    end
    reset    = 1'b0;
    bus.load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
